// File: rtl/fc_argmax_stream_if.sv
// Logit stream from the FC layer into the argmax stage.
// Master drives beats; slave answers with in_ready.
interface fc_argmax_stream_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/fc_argmax_stream.sv
// Streaming argmax over N_OUT signed FC logits.
// Registers the winner and drives an active-low HEX digit.
module fc_argmax_stream #(
  parameter int N_OUT  = 10,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  fc_argmax_stream_if.slave s,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] max_val,
  output logic              err,
  output logic [6:0]        hex_seg
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OUT - 1);

  state_t                    state;
  state_t                    nxt;
  logic [IDX_W-1:0]          cnt;
  logic signed [DATA_W-1:0]  run_max;
  logic [IDX_W-1:0]          run_idx;
  logic                      early;
  logic                      acc;
  logic                      fin;
  logic                      take;
  logic [IDX_W-1:0]          win_idx;
  logic [DATA_W-1:0]         win_val;
  logic [3:0]                hex_in;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Handshake outputs are pure state decodes.
  assign s.in_ready = (state == COLLECT);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  assign acc  = s.in_valid & s.in_ready;
  assign fin  = acc & (cnt == LAST);
  // Strict > keeps the lower index on ties.
  assign take = (cnt == '0) ||
                ($signed(s.in_data) > run_max);

  assign win_idx = take ? cnt : run_idx;
  assign win_val = take ? s.in_data : run_max;
  assign hex_in  = 4'(win_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = COLLECT;
      COLLECT: if (fin)   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      early     <= 1'b0;
      class_idx <= '0;
      max_val   <= '0;
      err       <= 1'b0;
      hex_seg   <= 7'b1111111;
    end else if (state == IDLE) begin
      cnt     <= '0;
      run_max <= '0;
      run_idx <= '0;
      early   <= 1'b0;
    end else if (acc) begin
      cnt     <= cnt + 1'b1;
      run_max <= win_val;
      run_idx <= win_idx;
      if (s.in_last) early <= 1'b1;
      if (fin) begin
        class_idx <= win_idx;
        max_val   <= win_val;
        err       <= early | ~s.in_last;
        hex_seg   <= seg7(hex_in);
      end
    end
  end

endmodule

// File: tb/tb_fc_argmax_stream.sv
// Randomized bench for fc_argmax_stream.
// Reference model: plain argmax over the beat array.
module tb_fc_argmax_stream;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  class_idx;
  logic [31:0] max_val;
  logic        err;
  logic [6:0]  hex_seg;

  int n_checks;
  int n_errors;

  logic signed [31:0] vec [10];
  logic [9:0]         lmask;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  fc_argmax_stream_if #(.DATA_W(32)) bus ();

  fc_argmax_stream #(
    .N_OUT (10),
    .DATA_W(32),
    .IDX_W (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .s        (bus),
    .busy     (busy),
    .done     (done),
    .class_idx(class_idx),
    .max_val  (max_val),
    .err      (err),
    .hex_seg  (hex_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(
    output int          idx,
    output logic [31:0] val,
    output bit          e
  );
    idx = 0;
    for (int i = 1; i < 10; i++)
      if (vec[i] > vec[idx]) idx = i;
    val = vec[idx];
    e = !lmask[9] || (lmask[8:0] != 9'd0);
  endtask

  task automatic run(
    input int gap,
    input bit poke,
    input bit lat
  );
    int          b;
    int          n;
    bit          got;
    bit          acc;
    int          eidx;
    logic [31:0] eval;
    bit          eerr;
    model(eidx, eval, eerr);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n   = 1;
    b   = 0;
    got = 0;
    while (!got && n < 300) begin
      bus.in_valid = (b < 10) &&
                     ($urandom_range(99) >= gap);
      bus.in_data  = vec[b < 10 ? b : 9];
      bus.in_last  = lmask[b < 10 ? b : 9];
      start = poke && ($urandom_range(3) == 0);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) b++;
      #1;
      n++;
      start = 1'b0;
      if (done) got = 1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    if (!got) return;
    check("beats", b, 10);
    if (lat) check("latency", n, 11);
    check("class_idx", 32'(class_idx), eidx);
    check("max_val", max_val, eval);
    check("err", 32'(err), 32'(eerr));
    check("hex_seg", 32'(hex_seg), 32'(HEX[eidx]));
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_ready", 32'(bus.in_ready), 32'd0);
    check("held_idx", 32'(class_idx), eidx);
  endtask

  initial begin
    int dones;
    int k;
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset asserted mid-cycle, outputs checked before any edge
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_hex", 32'(hex_seg), 32'h7F);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(class_idx), 32'd0);
    check("rst_max", max_val, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    bus.in_valid = 1'b1;
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || bus.in_ready) dones++;
    end
    bus.in_valid = 1'b0;
    check("idle_no_done", dones, 0);

    vec = '{5, -3, 12, 7, 0, 1, 2, 3, 4, -100};
    lmask = 10'b10_0000_0000;
    run(0, 0, 1);

    for (int i = 0; i < 10; i++)
      vec[i] = -$signed(32'($urandom_range(1000, 2)));
    vec[3] = -1;
    vec[7] = -1;
    run(0, 0, 1);

    for (int i = 0; i < 10; i++) vec[i] = 32'h8000_0000;
    vec[5] = 32'h7FFF_FFFF;
    run(0, 0, 1);

    vec = '{5, -3, 12, 7, 0, 1, 2, 3, 4, -100};
    run(50, 1, 0);

    lmask = 10'b00_0001_0000;
    run(0, 0, 1);
    lmask = 10'b10_0000_0000;
    run(0, 0, 1);

    // reset after five accepted beats
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bus.in_valid = 1'b1;
    repeat (5) begin
      bus.in_data = $urandom;
      @(posedge clk);
      #1;
    end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_idx", 32'(class_idx), 32'd0);
    check("mid_rst_hex", 32'(hex_seg), 32'h7F);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++)
      vec[i] = $signed(32'($urandom_range(500)));
    vec[7] = 1000;
    run(0, 0, 1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 10; i++) vec[i] = $urandom;
      k = $urandom_range(9);
      vec[$urandom_range(9)] = vec[k];
      lmask = 10'b10_0000_0000;
      if ($urandom_range(2) == 0)
        lmask = 10'($urandom);
      run(30, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
